// File: rtl/pzbcm_ram_read_ctrl_resp_queue.sv
// Circular response queue (non-power-of-2 depth). Push visible next cycle; 0-cycle pop.
// No internal backpressure: the caller's credit check keeps pushes away from a full queue.
module pzbcm_ram_read_ctrl_resp_queue #(
  parameter int  DEPTH       = 2,
  parameter int  COUNT_WIDTH = $clog2(DEPTH + 1),
  parameter type DATA_TYPE   = logic [7:0]
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  DATA_TYPE               i_data,
  input  logic                   i_pop,
  output DATA_TYPE               o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_empty
);
  localparam int PTR_WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

  DATA_TYPE               r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/pzbcm_ram_read_ctrl.sv
// RAM read initiator: valid/ready requests -> RAM me/adr, returned q queued in order; response after READ_LATENCY+1 cycles.
// Credit-based request ready (queue + inflight < RESPONSE_DEPTH); response backpressure never reaches o_req_ready combinationally.
module pzbcm_ram_read_ctrl #(
  parameter int  WORD_SIZE      = 1,
  parameter int  ADDRESS_WIDTH  = (WORD_SIZE >= 2) ? $clog2(WORD_SIZE) : 1,
  parameter int  DATA_WIDTH     = 8,
  parameter type DATA_TYPE      = logic [DATA_WIDTH-1:0],
  parameter int  READ_LATENCY   = 0,
  parameter int  RESPONSE_DEPTH = READ_LATENCY + 2
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output DATA_TYPE                 o_resp_data,
  output logic                     o_meb,
  output logic [ADDRESS_WIDTH-1:0] o_adrb,
  input  DATA_TYPE                 i_qb
);
  localparam int COUNT_WIDTH  = $clog2(RESPONSE_DEPTH + 1);
  localparam int CREDIT_WIDTH = COUNT_WIDTH + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_LIMIT = CREDIT_WIDTH'(RESPONSE_DEPTH);

  if (!(READ_LATENCY inside {0, 1})) begin : g_bad_latency
    $error("pzbcm_ram_read_ctrl: READ_LATENCY must be 0 or 1");
  end
  if (RESPONSE_DEPTH < 1) begin : g_bad_depth
    $error("pzbcm_ram_read_ctrl: RESPONSE_DEPTH must be >= 1");
  end

  logic                     w_fire;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_inflight;
  logic                     w_empty;
  logic [COUNT_WIDTH-1:0]   w_count;
  logic [CREDIT_WIDTH-1:0]  w_credit_used;
  DATA_TYPE                 w_queue_data;
  logic [ADDRESS_WIDTH-1:0] r_adrb;

  // Every fired read owns a queue slot until it is popped, so the inflight read counts too.
  assign w_credit_used = {1'b0, w_count} + CREDIT_WIDTH'(w_inflight);
  assign o_req_ready   = i_rst_n && !i_clr && (w_credit_used < CREDIT_LIMIT);
  assign w_fire        = i_req_valid && o_req_ready;

  assign o_meb  = w_fire;
  assign o_adrb = w_fire ? i_req_addr : r_adrb;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_adrb <= '0;
    end else if (w_fire) begin
      r_adrb <= i_req_addr;
    end
  end

  if (READ_LATENCY == 1) begin : g_pipe
    logic r_inflight;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_fire;
      end
    end

    // Data landing during a clear belongs to a flushed request and is dropped.
    assign w_inflight = r_inflight;
    assign w_push     = r_inflight && !i_clr;
  end else begin : g_no_pipe
    assign w_inflight = 1'b0;
    assign w_push     = w_fire;
  end

  assign o_resp_valid = i_rst_n && !w_empty;
  assign w_pop        = o_resp_valid && i_resp_ready && !i_clr;
  assign o_resp_data  = w_queue_data;

  pzbcm_ram_read_ctrl_resp_queue #(
    .DEPTH       (RESPONSE_DEPTH),
    .COUNT_WIDTH (COUNT_WIDTH),
    .DATA_TYPE   (DATA_TYPE)
  ) u_resp_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_push  (w_push),
    .i_data  (i_qb),
    .i_pop   (w_pop),
    .o_data  (w_queue_data),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule
